// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: raster timing generator with a built-in test-pattern source.
// Produces registered RGB/hsync/vsync/DE plus pixel coordinates and frame/line strobes.
// Default parameters give 720p60.
// Optional feature: define VTG_BORDER_EN to paint a one-pixel red border around the active area.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pattern_sel,
    input  logic [23:0]   solid_rgb,
    output logic [7:0]    rgb_r,
    output logic [7:0]    rgb_g,
    output logic [7:0]    rgb_b,
    output logic          rgb_hs,
    output logic          rgb_vs,
    output logic          rgb_de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          frame_start,
    output logic          line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    // Last in-bar count of a colour bar; remainder pixels stay in bar 7.
    localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);
`ifdef VTG_BORDER_EN
    localparam logic [CW-1:0] X_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_ACTIVE - 1);
`endif

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [2:0]    bar_idx;
    logic [CW-1:0] bar_cnt;
    logic [1:0]    pat_q;
    logic [23:0]   solid_q;

    logic          frame_origin;
    logic          in_active;
    logic          in_hs;
    logic          in_vs;
    logic          line_origin;
    logic [1:0]    pat_cur;
    logic [23:0]   solid_cur;
    logic [23:0]   colour;

    // Raster counters: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Incremental colour-bar tracker, restarted at the start of each line (no divider).
    always_ff @(posedge clk) begin
        if (rst || h_cnt == H_LAST) begin
            bar_idx <= '0;
            bar_cnt <= '0;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 1'b1;
            end
        end else begin
            bar_cnt <= bar_cnt + 1'b1;
        end
    end

    // Pattern selection is captured only at the frame origin so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= 2'd0;
            solid_q <= 24'h000000;
        end else if (frame_origin) begin
            pat_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    // Region decode of the current counter state.
    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        line_origin  = (h_cnt == '0) && (v_cnt < V_ACT);
        in_active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hs        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        in_vs        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        // The origin pixel already uses the freshly sampled selection.
        pat_cur      = frame_origin ? pattern_sel : pat_q;
        solid_cur    = frame_origin ? solid_rgb : solid_q;
    end

    // Pixel colour for the current counter state; blanked outside the active area.
    always_comb begin
        colour = 24'h000000;
        case (pat_cur)
            2'd0: colour = 24'hFFFFFF;
            // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
            2'd1: colour = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd2: colour = (h_cnt[5] ^ v_cnt[5]) ? 24'h000000 : 24'hFFFFFF;
            default: colour = solid_cur;
        endcase
`ifdef VTG_BORDER_EN
        if (h_cnt == '0 || h_cnt == X_LAST || v_cnt == '0 || v_cnt == Y_LAST) begin
            colour = 24'hFF0000;
        end
`endif
        if (!in_active) begin
            colour = 24'h000000;
        end
    end

    // Output register stage: everything describes the previous cycle's counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            {rgb_r, rgb_g, rgb_b} <= 24'h000000;
            rgb_hs      <= ~HS_POL;
            rgb_vs      <= ~VS_POL;
            rgb_de      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            {rgb_r, rgb_g, rgb_b} <= colour;
            rgb_hs      <= in_hs ? HS_POL : ~HS_POL;
            rgb_vs      <= in_vs ? VS_POL : ~VS_POL;
            rgb_de      <= in_active;
            pix_x       <= in_active ? h_cnt : '0;
            pix_y       <= in_active ? v_cnt : '0;
            frame_start <= frame_origin;
            line_start  <= line_origin;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: randomized, model-based bench for video_timing_pattern_gen.
// Two instances: 16-pixel active width (HS active-low) and a 20-pixel variant for bar remainders.
module tb_video_timing_pattern_gen;

    localparam int FRAME_A = 24 * 12;
    localparam int FRAME_B = 28 * 12;
    localparam logic [44:0] RESET_VEC = {24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h000000;

    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, a_de, a_fs, a_ls, b_hs, b_vs, b_de, b_fs, b_ls;
    logic [7:0] a_x, a_y, b_x, b_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CW(8)
    ) dut_a (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .rgb_r(a_r), .rgb_g(a_g), .rgb_b(a_b), .rgb_hs(a_hs), .rgb_vs(a_vs), .rgb_de(a_de),
        .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs), .line_start(a_ls)
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CW(8)
    ) dut_b (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .rgb_r(b_r), .rgb_g(b_g), .rgb_b(b_b), .rgb_hs(b_hs), .rgb_vs(b_vs), .rgb_de(b_de),
        .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs), .line_start(b_ls)
    );

    logic [44:0] act_a, act_b;
    assign act_a = {a_r, a_g, a_b, a_hs, a_vs, a_de, a_x, a_y, a_fs, a_ls};
    assign act_b = {b_r, b_g, b_b, b_hs, b_vs, b_de, b_x, b_y, b_fs, b_ls};

    // ---------------- reference model ----------------
    function automatic logic [23:0] bar_colour(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic is_edge(input int x, input int y, input int ha);
`ifdef VTG_BORDER_EN
        return (x == 0) || (x == ha - 1) || (y == 0) || (y == 7);
`else
        return 1'b0 && (x == ha + y);
`endif
    endfunction

    // Expected outputs for position p (cycles since frame origin), active width ha.
    function automatic logic [44:0] model_out(input int ha, input int p, input logic [1:0] pat,
                                              input logic [23:0] solid);
        int ht, h, v, b;
        logic act, hs, vs;
        logic [23:0] c;
        logic [7:0] x, y;
        ht  = ha + 8;
        h   = p % ht;
        v   = (p / ht) % 12;
        act = (h < ha) && (v < 8);
        case (pat)
            2'd0: c = 24'hFFFFFF;
            2'd1: begin
                b = h / (ha / 8);
                if (b > 7) b = 7;
                c = bar_colour(b);
            end
            2'd2: c = ((((h / 32) + (v / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
            default: c = solid;
        endcase
        if (is_edge(h, v, ha)) c = 24'hFF0000;
        if (!act) c = 24'h000000;
        hs = !((h >= ha + 2) && (h < ha + 5));
        vs = (v >= 9) && (v < 11);
        x  = act ? 8'(h) : 8'd0;
        y  = act ? 8'(v) : 8'd0;
        return {c, hs, vs, act, x, y, (h == 0) && (v == 0), (h == 0) && (v < 8)};
    endfunction

    int          cyc = 0;
    logic [25:0] lat_a = 26'd0;
    logic [25:0] lat_b = 26'd0;
    logic [44:0] exp_a = RESET_VEC;
    logic [44:0] exp_b = RESET_VEC;

    always @(posedge clk) begin
        if (rst) begin
            cyc   <= 0;
            lat_a <= 26'd0;
            lat_b <= 26'd0;
            exp_a <= RESET_VEC;
            exp_b <= RESET_VEC;
        end else begin
            if (cyc % FRAME_A == 0) begin
                lat_a <= {pattern_sel, solid_rgb};
                exp_a <= model_out(16, cyc, pattern_sel, solid_rgb);
            end else begin
                exp_a <= model_out(16, cyc, lat_a[25:24], lat_a[23:0]);
            end
            if (cyc % FRAME_B == 0) begin
                lat_b <= {pattern_sel, solid_rgb};
                exp_b <= model_out(20, cyc, pattern_sel, solid_rgb);
            end else begin
                exp_b <= model_out(20, cyc, lat_b[25:24], lat_b[23:0]);
            end
            cyc <= cyc + 1;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (act_a !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_a: got %h want %h", act_a, RESET_VEC);
            end
            checks++;
            if (act_b !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_b: got %h want %h", act_b, RESET_VEC);
            end
        end
    endtask

    task automatic test_timing();
        int de_frame = 0, de_line = 0, white_bad = 0, fs1 = -1, fs2 = -1;
        pattern_sel = 2'd0;
        rst = 1'b0;
        for (int t = 1; t <= 2 * FRAME_A; t++) begin
            @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL timing_vec t=%0d got %h %h want %h %h", t, act_a, act_b, exp_a, exp_b);
            end
            if (a_fs) begin
                if (fs1 < 0) fs1 = t;
                else if (fs2 < 0) fs2 = t;
            end
            if (t <= FRAME_A && a_de) de_frame++;
            if (t <= 24 && a_de) de_line++;
            if (a_de && !is_edge(a_x, a_y, 16) && {a_r, a_g, a_b} !== 24'hFFFFFF) white_bad++;
        end
        checks++;
        if (fs1 != 1) begin errors++; $display("FAIL first_frame_start: got %0d want 1", fs1); end
        checks++;
        if (fs2 - fs1 != FRAME_A) begin errors++; $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FRAME_A); end
        checks++;
        if (de_frame != 128) begin errors++; $display("FAIL de_per_frame: got %0d want 128", de_frame); end
        checks++;
        if (de_line != 16) begin errors++; $display("FAIL de_per_line: got %0d want 16", de_line); end
        checks++;
        if (white_bad != 0) begin errors++; $display("FAIL white_pixels: got %0d bad want 0", white_bad); end
    endtask

    task automatic test_sync();
        int n = 0, hs_low = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
        do begin @(negedge clk); n++; end while (!a_fs && n < 400);
        checks++;
        if (!a_fs) begin errors++; $display("FAIL sync_wait: got no frame_start want one"); end
        for (int k = 0; k < FRAME_A; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL sync_vec k=%0d got %h %h want %h %h", k, act_a, act_b, exp_a, exp_b);
            end
            if (k < 24 && !a_hs) begin hs_low++; if (hs_first < 0) hs_first = k; end
            if (a_vs) begin vs_cnt++; if (vs_first < 0) vs_first = k; end
        end
        checks++;
        if (hs_low != 3) begin errors++; $display("FAIL hs_width: got %0d want 3", hs_low); end
        checks++;
        if (hs_first != 18) begin errors++; $display("FAIL hs_offset: got %0d want 18", hs_first); end
        checks++;
        if (vs_cnt != 48) begin errors++; $display("FAIL vs_width: got %0d want 48", vs_cnt); end
        checks++;
        if (vs_first != 216) begin errors++; $display("FAIL vs_offset: got %0d want 216", vs_first); end
    endtask

    task automatic test_bars();
        bit seen_a = 0, seen_b = 0;
        pattern_sel = 2'd1;
        for (int t = 0; t < 2 * FRAME_B; t++) begin
            @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL bars_vec t=%0d got %h %h want %h %h", t, act_a, act_b, exp_a, exp_b);
            end
            if (a_fs) seen_a = 1;
            if (b_fs) seen_b = 1;
            if (seen_a && a_de && a_y >= 1 && a_y <= 6 && (a_x == 2 || a_x == 14)) begin
                checks++;
                if ({a_r, a_g, a_b} !== ((a_x == 2) ? 24'hFFFF00 : 24'h000000)) begin
                    errors++;
                    $display("FAIL bar16 x=%0d: got %h", a_x, {a_r, a_g, a_b});
                end
            end
            if (seen_b && b_de && b_y >= 1 && b_y <= 6 && b_x >= 12 && b_x <= 18) begin
                checks++;
                if ({b_r, b_g, b_b} !== ((b_x < 14) ? 24'h0000FF : 24'h000000)) begin
                    errors++;
                    $display("FAIL bar20 x=%0d: got %h", b_x, {b_r, b_g, b_b});
                end
            end
        end
    endtask

    task automatic test_latch();
        int n = 0, white_bad = 0;
        pattern_sel = 2'd0;
        do begin @(negedge clk); n++; end while (!a_fs && n < 400);
        repeat (100) begin
            @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL latch_vec got %h %h want %h %h", act_a, act_b, exp_a, exp_b);
            end
        end
        pattern_sel = 2'd3;
        solid_rgb   = 24'h123456;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL latch_vec got %h %h want %h %h", act_a, act_b, exp_a, exp_b);
            end
            if (!a_fs && a_de && !is_edge(a_x, a_y, 16) && {a_r, a_g, a_b} !== 24'hFFFFFF) white_bad++;
        end while (!a_fs && n < 400);
        checks++;
        if (!a_fs) begin errors++; $display("FAIL latch_wait: got no frame_start want one"); end
        checks++;
        if (white_bad != 0) begin errors++; $display("FAIL latch_tear: got %0d changed pixels want 0", white_bad); end
        checks++;
        if ({a_r, a_g, a_b} !== (is_edge(0, 0, 16) ? 24'hFF0000 : 24'h123456)) begin
            errors++;
            $display("FAIL latch_origin: got %h", {a_r, a_g, a_b});
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!a_ls && n < 400);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({act_a, act_b} !== {RESET_VEC, RESET_VEC}) begin
            errors++;
            $display("FAIL midreset_state: got %h %h want %h", act_a, act_b, RESET_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_fs, a_de, a_x, a_y} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL midreset_origin: got fs=%b de=%b x=%0d y=%0d", a_fs, a_de, a_x, a_y);
        end
        @(negedge clk);
        checks++;
        if ({a_fs, a_x, a_y} !== {1'b0, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL midreset_next: got fs=%b x=%0d y=%0d", a_fs, a_x, a_y);
        end
        checks++;
        if ({act_a, act_b} !== {exp_a, exp_b}) begin
            errors++;
            $display("FAIL midreset_vec got %h %h want %h %h", act_a, act_b, exp_a, exp_b);
        end
    endtask

    task automatic test_border();
        int n = 0, red = 0, green = 0, want_red, want_green;
        pattern_sel = 2'd3;
        solid_rgb   = 24'h00FF00;
        want_red    = is_edge(0, 0, 16) ? 44 : 0;
        want_green  = 128 - want_red;
        do begin @(negedge clk); n++; end while (!a_fs && n < 400);
        for (int k = 0; k < FRAME_A; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL border_vec k=%0d got %h %h want %h %h", k, act_a, act_b, exp_a, exp_b);
            end
            if (a_de && {a_r, a_g, a_b} === 24'hFF0000) red++;
            if (a_de && {a_r, a_g, a_b} === 24'h00FF00) green++;
        end
        checks++;
        if (red != want_red) begin errors++; $display("FAIL border_red: got %0d want %0d", red, want_red); end
        checks++;
        if (green != want_green) begin errors++; $display("FAIL border_green: got %0d want %0d", green, want_green); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            checks++;
            if ({act_a, act_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL random_vec t=%0d got %h %h want %h %h", t, act_a, act_b, exp_a, exp_b);
            end
            if ($urandom_range(49) == 0) begin
                pattern_sel = 2'($urandom);
                solid_rgb   = 24'($urandom);
            end
            rst = ($urandom_range(399) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_sync();
        test_bars();
        test_latch();
        test_reset_mid();
        test_border();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
